mips_branch_predictor: RTL and testbench

Parametrised branch target buffer with 2-bit saturating direction counters for the five-stage MIPS pipeline. Sits beside the IF stage: IF looks up the fetch PC each cycle to get a predicted next PC. ID resolves branches and jumps and writes the outcome back, and the block flags mispredictions so the hazard logic can flush IF/ID. Replaces the fixed not-taken fetch policy.

---
 rtl/mips_bp_pkg.sv | 33 +++
 rtl/bp_sat_counter.sv | 20 ++
 rtl/mips_branch_predictor.sv | 121 ++++++++++++
 tb/tb_mips_branch_predictor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bp_pkg.sv
// Shared types and helpers for the MIPS branch target buffer.
package mips_bp_pkg;

  // Sequential fetch step; MIPS instructions are one word.
  localparam int unsigned PC_INC = 4;

  // Widest legal geometry, used to size the generic entry record.
  localparam int unsigned BP_PC_W_MAX  = 32;
  localparam int unsigned BP_CNT_W_MAX = 4;

  // One BTB entry at the widest geometry; narrower instances zero-extend into it.
  typedef struct packed {
    logic                    valid;
    logic [BP_PC_W_MAX-1:0]  tag;
    logic [BP_PC_W_MAX-1:0]  target;
    logic [BP_CNT_W_MAX-1:0] cnt;
  } bp_entry_t;

  // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  function automatic logic [BP_CNT_W_MAX-1:0] CNT_WNT(input int unsigned w);
    logic [BP_CNT_W_MAX-1:0] one;
    one = 1;
    return (one << (w - 1)) - one;
  endfunction

  // Weakly-taken: MSB set, all lower bits clear.
  function automatic logic [BP_CNT_W_MAX-1:0] CNT_WT(input int unsigned w);
    logic [BP_CNT_W_MAX-1:0] one;
    one = 1;
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating counter step: returns the next counter value for one update.
module bp_sat_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             up,
  output logic [CNT_W-1:0] cnt_nxt
);

  // Step toward all-ones on taken, toward zero on not-taken, holding at either end.
  always_comb begin
    cnt_nxt = cnt;
    if (up) begin
      if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + 1'b1;
    end else begin
      if (cnt != '0) cnt_nxt = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB with saturating direction counters beside the IF stage.
// Lookup is combinational; ID writes back resolved outcomes and gets mispredict flags.
module mips_branch_predictor
  import mips_bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_npc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic [PC_W-1:0] upd_pred_npc,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     mispredict_cnt,
  output logic [31:0]     lookup_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  localparam logic [CNT_W-1:0] CntWnt = CNT_W'(CNT_WNT(CNT_W));
  localparam logic [CNT_W-1:0] CntWt  = CNT_W'(CNT_WT(CNT_W));
  localparam logic [PC_W-1:0]  PcInc  = PC_W'(PC_INC);

  // Register-array storage: async reset and zero-latency read rule out SRAM.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic [31:0]      lookup_cnt_d, lookup_cnt_q;
  logic [31:0]      mispredict_cnt_d, mispredict_cnt_q;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[PC_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];

  // Fetch-side lookup; sees pre-update state, no bypass from the write port.
  always_comb begin
    pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = pred_hit && cnt_q[lk_idx][CNT_W-1];
    pred_npc   = pred_taken ? target_q[lk_idx] : if_pc + PcInc;
  end

  // Resolution check against the prediction carried down the pipe.
  always_comb begin
    up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    redirect_pc = upd_taken ? upd_target : upd_pc + PcInc;
    mispredict  = upd_valid && (redirect_pc != upd_pred_npc);
  end

  bp_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .cnt     (cnt_q[up_idx]),
    .up      (upd_taken),
    .cnt_nxt (cnt_nxt)
  );

  // Table write: clear dominates any same-cycle allocation or training.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CntWnt;
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (upd_valid) begin
      if (up_hit) begin
        cnt_q[up_idx] <= cnt_nxt;
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        cnt_q[up_idx]    <= CntWt;
      end
    end
  end

  // Statistics next-state: saturate at all-ones instead of wrapping.
  always_comb begin
    lookup_cnt_d     = lookup_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (upd_valid && (lookup_cnt_q != '1)) lookup_cnt_d = lookup_cnt_q + 32'd1;
    if (mispredict && (mispredict_cnt_q != '1)) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  // Statistics registers; unaffected by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookup_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      lookup_cnt_q     <= lookup_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign lookup_cnt     = lookup_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Randomised bench for mips_branch_predictor against a behavioural BTB model.
module tb_mips_branch_predictor;
  import mips_bp_pkg::*;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_npc;
  logic        upd_valid, upd_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_npc;
  logic        mispredict;
  logic [31:0] redirect_pc, mispredict_cnt, lookup_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model: entry records plus plain integer statistics.
  bp_entry_t   m_tab [N];
  longint      m_lookups, m_misses;

  always #5 clk = ~clk;

  mips_branch_predictor #(
    .ENTRIES (N),
    .PC_W    (32),
    .CNT_W   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .if_pc          (if_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_npc       (pred_npc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_npc   (upd_pred_npc),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .mispredict_cnt (mispredict_cnt),
    .lookup_cnt     (lookup_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_tab[i].valid  = 1'b0;
      m_tab[i].tag    = '0;
      m_tab[i].target = '0;
      m_tab[i].cnt    = 4'd1;
    end
    m_lookups = 0;
    m_misses  = 0;
  endtask

  function automatic logic m_hit(input logic [31:0] pc);
    return m_tab[idx_of(pc)].valid && (m_tab[idx_of(pc)].tag == tag_of(pc));
  endfunction

  function automatic logic [31:0] m_npc(input logic [31:0] pc);
    if (m_hit(pc) && m_tab[idx_of(pc)].cnt >= 2) return m_tab[idx_of(pc)].target;
    return pc + 32'd4;
  endfunction

  // One full cycle: drive, check every output against the model, clock, advance model.
  task automatic cyc(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                     input logic tk, input logic [31:0] tgt, input logic [31:0] pn,
                     input logic clr);
    logic [31:0] actual;
    logic        mis;
    int          k;
    if_pc = ipc; upd_valid = uv; upd_pc = upc; upd_taken = tk;
    upd_target = tgt; upd_pred_npc = pn; clear = clr;
    #1;
    actual = tk ? tgt : upc + 32'd4;
    mis    = uv && (actual != pn);
    check("pred_hit", {31'd0, pred_hit}, {31'd0, m_hit(ipc)});
    check("pred_taken", {31'd0, pred_taken},
          {31'd0, m_hit(ipc) && m_tab[idx_of(ipc)].cnt >= 2});
    check("pred_npc", pred_npc, m_npc(ipc));
    check("mispredict", {31'd0, mispredict}, {31'd0, mis});
    check("redirect_pc", redirect_pc, actual);
    check("lookup_cnt", lookup_cnt, 32'(m_lookups));
    check("mispredict_cnt", mispredict_cnt, 32'(m_misses));
    @(posedge clk);
    if (uv) m_lookups++;
    if (mis) m_misses++;
    k = idx_of(upc);
    if (clr) begin
      for (int i = 0; i < N; i++) m_tab[i].valid = 1'b0;
    end else if (uv) begin
      if (m_hit(upc)) begin
        if (tk) begin
          m_tab[k].cnt    = (m_tab[k].cnt == 3) ? 4'd3 : m_tab[k].cnt + 4'd1;
          m_tab[k].target = tgt;
        end else begin
          m_tab[k].cnt = (m_tab[k].cnt == 0) ? 4'd0 : m_tab[k].cnt - 4'd1;
        end
      end else if (tk) begin
        m_tab[k].valid  = 1'b1;
        m_tab[k].tag    = tag_of(upc);
        m_tab[k].target = tgt;
        m_tab[k].cnt    = 4'd2;
      end
    end
    @(negedge clk);
  endtask

  // Drive a quiet lookup so explicit checks see settled outputs.
  task automatic look(input logic [31:0] pc);
    if_pc = pc; upd_valid = 1'b0; clear = 1'b0;
    #1;
  endtask

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] TA = 32'h0040_0100;

  logic [31:0] r_pc, r_tgt, r_pn, r_ipc;
  logic        r_uv, r_tk, r_clr;

  initial begin
    rst = 1'b1; clear = 1'b0; if_pc = PA; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_npc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    look(PA);
    check("rst_hit", {31'd0, pred_hit}, 32'd0);
    check("rst_npc", pred_npc, 32'h0040_0014);
    check("rst_lookups", lookup_cnt, 32'd0);
    check("rst_misses", mispredict_cnt, 32'd0);

    // First taken resolution allocates; same-cycle lookup still sees the empty entry.
    cyc(PA, 1'b1, PA, 1'b1, TA, 32'h0040_0014, 1'b0);
    look(PA);
    check("alloc_hit", {31'd0, pred_hit}, 32'd1);
    check("alloc_taken", {31'd0, pred_taken}, 32'd1);
    check("alloc_npc", pred_npc, TA);
    check("alloc_misses", mispredict_cnt, 32'd1);

    // Weakly-taken -> 01 (not-taken) -> 00 -> stays 00.
    cyc(PA, 1'b1, PA, 1'b0, TA, TA, 1'b0);
    look(PA);
    check("nt1_taken", {31'd0, pred_taken}, 32'd0);
    cyc(PA, 1'b1, PA, 1'b0, TA, PA + 4, 1'b0);
    cyc(PA, 1'b1, PA, 1'b0, TA, PA + 4, 1'b0);
    // Four taken from 00 saturate at 11; one not-taken still predicts taken.
    for (int i = 0; i < 4; i++) cyc(PA, 1'b1, PA, 1'b1, TA, m_npc(PA), 1'b0);
    cyc(PA, 1'b1, PA, 1'b0, TA, TA, 1'b0);
    look(PA);
    check("sat_taken", {31'd0, pred_taken}, 32'd1);

    // Aliasing on index 0 and eviction.
    cyc(32'h0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_1000, 32'h0000_0044, 1'b0);
    look(32'h0001_0040);
    check("alias_miss", {31'd0, pred_hit}, 32'd0);
    cyc(32'h0000_0040, 1'b1, 32'h0001_0040, 1'b1, 32'h0000_2000, 32'h0001_0044, 1'b0);
    look(32'h0000_0040);
    check("evicted", {31'd0, pred_hit}, 32'd0);

    // Clear beats a same-cycle allocation; statistics still count it.
    cyc(PA, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_3000, 32'h0000_0084, 1'b1);
    look(PA);
    check("clear_hit", {31'd0, pred_hit}, 32'd0);
    cyc(32'h0000_0080, 1'b0, '0, 1'b0, '0, '0, 1'b0);

    // PC wrap at the top of the address space.
    cyc(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 32'h0, 1'b0);

    // Randomised traffic over a small set of tags so entries collide and train.
    for (int n = 0; n < 600; n++) begin
      r_pc  = {14'd0, 2'($urandom_range(0, 2)), 10'd0, 4'($urandom), 2'($urandom)};
      r_ipc = ($urandom_range(0, 1) == 0) ? r_pc
            : {14'd0, 2'($urandom_range(0, 2)), 10'd0, 4'($urandom), 2'($urandom)};
      r_uv  = ($urandom_range(0, 3) != 0);
      r_tk  = $urandom_range(0, 1) == 1;
      r_tgt = {16'd0, 14'($urandom), 2'b00};
      r_pn  = ($urandom_range(0, 4) == 0) ? $urandom : m_npc(r_pc);
      r_clr = ($urandom_range(0, 40) == 0);
      cyc(r_ipc, r_uv, r_pc, r_tk, r_tgt, r_pn, r_clr);
    end

    // Asynchronous reset between edges empties the table at once.
    cyc(PA, 1'b1, PA, 1'b1, TA, PA + 4, 1'b0);
    look(PA);
    check("pre_rst_hit", {31'd0, pred_hit}, 32'd1);
    #2 rst = 1'b1;
    upd_valid = 1'b1; upd_pc = PA; upd_taken = 1'b1;
    #1;
    check("async_rst_hit", {31'd0, pred_hit}, 32'd0);
    check("async_rst_lookups", lookup_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    cyc(PA, 1'b0, PA, 1'b0, '0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
